// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: bus/tag geometry, requester
// IDs, selector bit positions and the transaction FSM states.
package mem_bus_pkg;

  localparam int BUS_W = 64;
  localparam int TAG_W = 4;
  localparam int ID_W  = 3;

  // Tag layout: bit 0 is the write flag, bits [1:3] carry the requester ID.
  localparam logic            TAG_WRITE = 1'b1;
  localparam logic            TAG_READ  = 1'b0;
  localparam logic [ID_W-1:0] ID_FETCH  = 3'd1;
  localparam logic [ID_W-1:0] ID_LOAD   = 3'd2;
  localparam logic [ID_W-1:0] ID_STORE  = 3'd3;

  // Bit positions inside the one-hot requester select.
  localparam int SEL_FETCH = 0;
  localparam int SEL_LOAD  = 1;
  localparam int SEL_STORE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RESP,
    ST_DONE
  } state_e;

  function automatic logic [0:TAG_W-1] make_tag(input logic wr, input logic [ID_W-1:0] id);
    return {wr, id};
  endfunction

endpackage

// File: rtl/mem_bus_prio_sel.sv
// Combinational requester selector: store > load > fetch, except that a fetch
// that has waited behind FAIR_LIMIT data grants wins outright.
module mem_bus_prio_sel
  import mem_bus_pkg::*;
#(
  parameter int FAIR_LIMIT = 4,
  parameter int FAIR_W     = 3
) (
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [FAIR_W-1:0] fair_cnt,
  output logic [2:0]        sel
);

  always_comb begin
    sel = '0;
    if (fetch_req && (fair_cnt == FAIR_W'(FAIR_LIMIT))) begin
      sel[SEL_FETCH] = 1'b1;
    end else if (store_req) begin
      sel[SEL_STORE] = 1'b1;
    end else if (load_req) begin
      sel[SEL_LOAD] = 1'b1;
    end else if (fetch_req) begin
      sel[SEL_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-owner arbiter between fetch, load and store paths and the shared
// system bus: address/data beats out, tagged line responses back.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int LINE_BEATS = 8,
  parameter int FAIR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [0:BUS_W-1] fetch_addr,
  output logic             fetch_grant,
  output logic [0:BUS_W-1] fetch_data,
  output logic             fetch_valid,
  output logic             fetch_last,
  input  logic             load_req,
  input  logic [0:BUS_W-1] load_addr,
  output logic             load_grant,
  output logic [0:BUS_W-1] load_data,
  output logic             load_done,
  input  logic             store_req,
  input  logic [0:BUS_W-1] store_addr,
  input  logic [0:BUS_W-1] store_data,
  output logic             store_grant,
  output logic             store_done,
  output logic             bus_reqcyc,
  output logic [0:BUS_W-1] bus_req,
  output logic [0:TAG_W-1] bus_reqtag,
  input  logic             bus_reqack,
  input  logic             bus_respcyc,
  input  logic [0:BUS_W-1] bus_resp,
  input  logic [0:TAG_W-1] bus_resptag,
  output logic             bus_respack
);

  localparam int         FAIR_W    = $clog2(FAIR_LIMIT + 1);
  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  state_e             state_q, state_d;
  logic [2:0]         sel;
  logic [FAIR_W-1:0]  fair_q, fair_d;
  logic [2:0]         beat_q, beat_d;
  logic [2:0]         grant_q, grant_d;
  logic [0:BUS_W-1]   addr_q, addr_d;
  logic [0:BUS_W-1]   wdata_q, wdata_d;
  logic [0:BUS_W-1]   load_data_q, load_data_d;
  logic [0:TAG_W-1]   tag_q, tag_d;
  logic [ID_W-1:0]    owner;
  logic               is_write;
  logic               start;
  logic               resp_hit;
  logic               last_hit;

  mem_bus_prio_sel #(
    .FAIR_LIMIT (FAIR_LIMIT),
    .FAIR_W     (FAIR_W)
  ) u_prio_sel (
    .fetch_req (fetch_req),
    .load_req  (load_req),
    .store_req (store_req),
    .fair_cnt  (fair_q),
    .sel       (sel)
  );

  assign owner    = tag_q[1:TAG_W-1];
  assign is_write = tag_q[0];
  assign start    = (state_q == ST_IDLE) && (sel != 3'b000);
  // Only beats carrying our own tag are accepted; foreign beats stay unacked.
  assign resp_hit = (state_q == ST_RESP) && bus_respcyc && (bus_resptag == tag_q);
  assign last_hit = resp_hit && (beat_q == LAST_BEAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_ADDR;
      ST_ADDR:  if (bus_reqack) state_d = is_write ? ST_WDATA : ST_RESP;
      ST_WDATA: if (bus_reqack) state_d = ST_DONE;
      ST_RESP:  if (last_hit)   state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tag_d       = tag_q;
    fair_d      = fair_q;
    beat_d      = beat_q;
    load_data_d = load_data_q;
    grant_d     = 3'b000;
    if (start) begin
      grant_d = sel;
      beat_d  = 3'd0;
      if (sel[SEL_STORE]) begin
        addr_d  = store_addr;
        wdata_d = store_data;
        tag_d   = make_tag(TAG_WRITE, ID_STORE);
      end else if (sel[SEL_LOAD]) begin
        addr_d = load_addr;
        tag_d  = make_tag(TAG_READ, ID_LOAD);
      end else begin
        addr_d = fetch_addr;
        tag_d  = make_tag(TAG_READ, ID_FETCH);
      end
      if (sel[SEL_FETCH]) begin
        fair_d = '0;
      end else if (fetch_req && (fair_q != FAIR_W'(FAIR_LIMIT))) begin
        fair_d = fair_q + 1'b1;
      end
    end
    if (resp_hit) begin
      beat_d = beat_q + 3'd1;
      // Word offset within the 64-byte line selects which beat a load keeps.
      if ((owner == ID_LOAD) && (beat_q == addr_q[BUS_W-6:BUS_W-4])) begin
        load_data_d = bus_resp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      fair_q      <= '0;
      beat_q      <= '0;
      grant_q     <= '0;
      load_data_q <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tag_q       <= tag_d;
      fair_q      <= fair_d;
      beat_q      <= beat_d;
      grant_q     <= grant_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    store_done = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      ST_ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = tag_q;
      end
      ST_WDATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = wdata_q;
        bus_reqtag = tag_q;
      end
      ST_DONE: begin
        store_done = (owner == ID_STORE);
        load_done  = (owner == ID_LOAD);
      end
      default: ;
    endcase
    bus_respack = resp_hit;
    fetch_valid = resp_hit && (owner == ID_FETCH);
    fetch_data  = fetch_valid ? bus_resp : '0;
    fetch_last  = fetch_valid && (beat_q == LAST_BEAT);
    fetch_grant = grant_q[SEL_FETCH];
    load_grant  = grant_q[SEL_LOAD];
    store_grant = grant_q[SEL_STORE];
    load_data   = load_data_q;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences all memory-bus traffic for the core. Sits between the fetch unit, the MEM-stage load path (`data_reqFlag`) and the MEM-stage store path (`store_reqFlag`) on one side, and the single shared system bus on the other. It grants one requester at a time and drives the address and write-data beats. It counts response beats, delivers fetch lines, load words and store completions, and prevents fetch starvation behind back-to-back data operations.

## Interface
- `LINE_BEATS`, 8: 64-bit response beats per read transaction (one 64-byte line).
- `FAIR_LIMIT`, 4: consecutive data grants allowed while fetch is pending before fetch is forced.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetch_req` in 1, `fetch_addr` in [0:63]: line fetch request, held until `fetch_grant`.
- `fetch_grant` out 1: one-cycle pulse, request latched.
- `fetch_data` out [0:63], `fetch_valid` out 1, `fetch_last` out 1: streamed line beats; last beat flagged.
- `load_req` in 1, `load_addr` in [0:63]: load request, held until `load_grant`.
- `load_grant` out 1: one-cycle pulse.
- `load_data` out [0:63], `load_done` out 1: selected word; one-cycle done pulse.
- `store_req` in 1, `store_addr` in [0:63], `store_data` in [0:63]: store request, held until `store_grant`.
- `store_grant` out 1, `store_done` out 1: one-cycle pulses.
- `bus_reqcyc` out 1, `bus_req` out [0:63], `bus_reqtag` out [0:3], `bus_reqack` in 1: request channel.
- `bus_respcyc` in 1, `bus_resp` in [0:63], `bus_resptag` in [0:3], `bus_respack` out 1: response channel.

## Operation
- Tag: bit 0 = write; bits [1:3] = requester ID (FETCH=1, LOAD=2, STORE=3).
- FSM states: IDLE, ADDR, WDATA, RESP, DONE.
- IDLE: requests are sampled only in this state. Priority is store > load > fetch, except that `fair_cnt == FAIR_LIMIT` with `fetch_req` high selects fetch. On selection, the arbiter latches the address, store data, and tag, then goes to ADDR.
- `fair_cnt`: increments on each data grant while `fetch_req` is high. It saturates at FAIR_LIMIT and clears on any fetch grant.
- ADDR: `bus_reqcyc`=1, `bus_req`=latched address, `bus_reqtag`=latched tag. Held until `bus_reqack`. On ack, a store goes to WDATA; a read goes to RESP.
- WDATA: `bus_reqcyc`=1, `bus_req`=latched store data, tag unchanged. Held until `bus_reqack`, then goes to DONE.
- RESP: a beat is accepted only when `bus_respcyc` is high and `bus_resptag` equals the latched tag. `bus_respack` is asserted combinationally on exactly those cycles. Non-matching beats are not acked.
  - Beat counter `beat` is 3 bits wide, starts at 0 and increments per accepted beat.
  - Fetch: `fetch_data`=`bus_resp` and `fetch_valid`=1 on each accepted beat; `fetch_last`=1 when `beat==LINE_BEATS-1`.
  - Load: the beat with `beat == load_addr[58:60]` (word offset in line) is captured into `load_data`.
  - After beat LINE_BEATS-1 is accepted, go to DONE.
- DONE: one cycle. `store_done` or `load_done` pulses for the owning requester (fetch has no done pulse). Then go to IDLE.

## Timing
- Reset: state=IDLE, `fair_cnt`=0, `beat`=0. All outputs are 0, including `load_data`, `bus_req` and `bus_reqtag`. An in-flight transaction is abandoned; no done pulse is issued.
- Grant latency: request high in IDLE cycle N, so `*_grant` pulses and `bus_reqcyc` rises in cycle N+1 (registered).
- `*_grant` is high only in the first ADDR cycle, even if ADDR is extended by a late `bus_reqack`.
- Store with zero-wait bus: grant at N+1, data beat at N+2, `store_done` at N+3, IDLE at N+4.
- Load/fetch: `load_done` is asserted the cycle after the last accepted beat. `load_data` stays stable from DONE until the next load captures a word.
- `fetch_valid`/`fetch_data` are combinational from the accepted beat and share its cycle.
- Requester rules:
  - A requester may drop its request after its grant; the level is ignored outside IDLE.
  - It must deassert by the edge ending its done cycle, otherwise it is re-granted.
- Simultaneous requests in IDLE: exactly one grant; the others wait with no state change.
- `bus_respcyc` outside RESP: `bus_respack`=0.

## Structure
- Shared package (`mem_bus_pkg`) holds the tag field constants (write bit, requester IDs FETCH/LOAD/STORE), the FSM state enum, and the bus width constant (64).
- One sub-module, `mem_bus_prio_sel`, is the combinational priority/fairness selector: inputs are the three requests and `fair_cnt`; output is a one-hot select.
- Everything else stays flat in `mem_bus_arbiter`.

## Test plan
- Store only: `store_addr`=0x1000, `store_data`=0xDEADBEEF, acks immediate → `bus_req` carries 0x1000 (tag 1011b) then 0xDEADBEEF; `store_done` at N+3.
- Load: `load_addr`=0x2018, 8 beats 0..7 carrying values 0xA0..0xA7 → `load_data`=0xA3, `load_done` once after beat 7.
- Fetch and load simultaneous → load granted first. Fetch is granted in the IDLE after load DONE; 8 `fetch_valid` beats with `fetch_last` on the 8th.
- Starvation: store_req and load_req alternate continuously with fetch_req held → the fifth grant goes to fetch (FAIR_LIMIT=4), after which `fair_cnt`=0.
- Foreign tag: in RESP, inject a beat with `bus_resptag`=0010b during a fetch → no `bus_respack`, beat count unchanged, line still completes with 8 beats.
- Reset mid-RESP at beat 4 → all outputs 0 the same cycle; after release, a fresh load completes correctly with no stale done pulse.
